fab_masked_vector_checker: RTL and testbench

- Synthesizable stimulus/response engine for the masked eFPGA fabric; replaces hand-written per-vector bench sequences with a streamed vector interface.
- Drives the dual-rail stimulus (true/false rails) into fabric user I/O.
- Waits a programmable settle time, then recombines the two output shares (XOR) over a configurable slice and compares against the expected value.
- Keeps an error count and captures the first failure; usable in simulation benches and on-chip self-test.

---
 rtl/fab_masked_vector_checker.sv | 184 ++++++++++++++++++
 tb/tb_fab_masked_vector_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fab_masked_vector_checker.sv
// Streamed stimulus/response checker for the masked eFPGA fabric: drives dual-rail stimulus,
// recombines two output shares after a settle delay and scores them. Optional macro: FAB_DUALRAIL_CHECK_EN.
module fab_masked_vector_checker #(
    parameter int IN_W    = 8,
    parameter int SH_W    = 60,
    parameter int OUT_LSB = 12,
    parameter int OUT_W   = 8,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [IN_W-1:0]  vec_stim,
    input  logic [OUT_W-1:0] vec_exp,
    input  logic             vec_last,
    output logic [IN_W-1:0]  stim_t,
    output logic [IN_W-1:0]  stim_f,
    output logic             stim_en,
    input  logic [SH_W-1:0]  share0_t,
    input  logic [SH_W-1:0]  share1_t,
`ifdef FAB_DUALRAIL_CHECK_EN
    input  logic [SH_W-1:0]  share0_f,
    input  logic [SH_W-1:0]  share1_f,
    output logic             rail_fault,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] fail_index,
    output logic [OUT_W-1:0] fail_got,
    output logic [OUT_W-1:0] fail_exp
);

    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READY  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // A rail pair is healthy when the false rail is the exact complement of the true rail.
    function automatic logic rail_pair_ok(input logic [OUT_W-1:0] t, input logic [OUT_W-1:0] f);
        return (f == ~t);
    endfunction

    logic [1:0]        state_r;
    logic [WAIT_W-1:0] wait_r;
    logic [OUT_W-1:0]  exp_r;
    logic              last_r;
    logic [SH_W-1:0]   sh_x_s;
    logic [OUT_W-1:0]  got_s;
    logic              rail_bad_s;
    logic              mismatch_s;
    logic              err_sat_s;

    // Recombine the shares over the checked slice and decide whether this vector fails.
    always_comb begin
        sh_x_s     = share0_t ^ share1_t;
        got_s      = sh_x_s[OUT_LSB +: OUT_W];
        rail_bad_s = 1'b0;
`ifdef FAB_DUALRAIL_CHECK_EN
        if (!rail_pair_ok(share0_t[OUT_LSB +: OUT_W], share0_f[OUT_LSB +: OUT_W]) ||
            !rail_pair_ok(share1_t[OUT_LSB +: OUT_W], share1_f[OUT_LSB +: OUT_W])) begin
            rail_bad_s = 1'b1;
        end else begin
            rail_bad_s = 1'b0;
        end
`endif
        mismatch_s = (got_s != exp_r) || rail_bad_s;
        err_sat_s  = &err_count;
    end

    assign pass = done && (err_count == {CNT_W{1'b0}});

    // Run sequencing: accept a vector, wait the settle time, score it, then loop or finish.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            wait_r     <= {WAIT_W{1'b0}};
            exp_r      <= {OUT_W{1'b0}};
            last_r     <= 1'b0;
            stim_t     <= {IN_W{1'b0}};
            stim_f     <= {IN_W{1'b1}};
            stim_en    <= 1'b0;
            vec_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_count  <= {CNT_W{1'b0}};
            err_count  <= {CNT_W{1'b0}};
            fail_index <= {CNT_W{1'b0}};
            fail_got   <= {OUT_W{1'b0}};
            fail_exp   <= {OUT_W{1'b0}};
`ifdef FAB_DUALRAIL_CHECK_EN
            rail_fault <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r    <= ST_READY;
                        vec_ready  <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        vec_count  <= {CNT_W{1'b0}};
                        err_count  <= {CNT_W{1'b0}};
                        fail_index <= {CNT_W{1'b0}};
                        fail_got   <= {OUT_W{1'b0}};
                        fail_exp   <= {OUT_W{1'b0}};
`ifdef FAB_DUALRAIL_CHECK_EN
                        rail_fault <= 1'b0;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_READY: begin
                    if (vec_valid) begin
                        stim_t    <= vec_stim;
                        stim_f    <= ~vec_stim;
                        stim_en   <= 1'b1;
                        exp_r     <= vec_exp;
                        last_r    <= vec_last;
                        wait_r    <= WAIT_W'(SETTLE - 1);
                        vec_ready <= 1'b0;
                        state_r   <= ST_SETTLE;
                    end else begin
                        state_r <= ST_READY;
                    end
                end
                ST_SETTLE: begin
                    if (wait_r != {WAIT_W{1'b0}}) begin
                        wait_r <= wait_r - {{(WAIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        vec_count <= vec_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (mismatch_s) begin
                            if (!err_sat_s) begin
                                err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
                            end else begin
                                err_count <= err_count;
                            end
                            if (err_count == {CNT_W{1'b0}}) begin
                                fail_index <= vec_count;
                                fail_got   <= got_s;
                                fail_exp   <= exp_r;
                            end else begin
                                fail_index <= fail_index;
                            end
                        end else begin
                            err_count <= err_count;
                        end
`ifdef FAB_DUALRAIL_CHECK_EN
                        if (rail_bad_s) begin
                            rail_fault <= 1'b1;
                        end else begin
                            rail_fault <= rail_fault;
                        end
`endif
                        if (last_r) begin
                            state_r <= ST_DONE;
                            stim_en <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state_r   <= ST_READY;
                            vec_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    vec_ready <= 1'b0;
                    busy      <= 1'b0;
                    stim_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fab_masked_vector_checker.sv
// Directed bench for fab_masked_vector_checker: a masked fabric model (resp = stim ^ 0xDA)
// feeds a default instance and a CNT_W=4 instance that share all inputs.
module tb_fab_masked_vector_checker;

    logic        CLK = 1'b0;
    logic        resetn;
    logic        start;
    logic        vec_valid;
    logic [7:0]  vec_stim;
    logic [7:0]  vec_exp;
    logic        vec_last;
    logic [59:0] share0_t;
    logic [59:0] share1_t;
    logic [63:0] mask_w;
    logic        vec_ready, stim_en, busy, done, pass;
    logic [7:0]  stim_t, stim_f, fail_got, fail_exp;
    logic [15:0] vec_count, err_count, fail_index;
    logic        s_vec_ready, s_stim_en, s_busy, s_done, s_pass;
    logic [7:0]  s_stim_t, s_stim_f, s_fail_got, s_fail_exp;
    logic [3:0]  s_vec_count, s_err_count, s_fail_index;
`ifdef FAB_DUALRAIL_CHECK_EN
    logic [59:0] share0_f, share1_f;
    logic        rail_fault, s_rail_fault;
    logic        flip;
`endif

    int checks = 0;
    int errors = 0;
    int waits;
    int min_w, max_w;
    logic [7:0] st;

    always #5 CLK = ~CLK;

    // Fabric model: fresh random mask every cycle, unmasked response = stim_t ^ 0xDA.
    always @(negedge CLK) mask_w <= {$urandom(), $urandom()};
    assign share0_t = mask_w[59:0];
    assign share1_t = mask_w[59:0] ^ {40'd0, stim_t ^ 8'hDA, 12'd0};
`ifdef FAB_DUALRAIL_CHECK_EN
    assign share0_f = ~share0_t;
    assign share1_f = ~share1_t ^ {47'd0, flip, 12'd0};
`endif

    fab_masked_vector_checker dut (
        .CLK(CLK), .resetn(resetn), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_stim(vec_stim), .vec_exp(vec_exp), .vec_last(vec_last), .stim_t(stim_t), .stim_f(stim_f),
        .stim_en(stim_en), .share0_t(share0_t), .share1_t(share1_t),
`ifdef FAB_DUALRAIL_CHECK_EN
        .share0_f(share0_f), .share1_f(share1_f), .rail_fault(rail_fault),
`endif
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
        .fail_index(fail_index), .fail_got(fail_got), .fail_exp(fail_exp)
    );

    fab_masked_vector_checker #(.CNT_W(4)) dut_small (
        .CLK(CLK), .resetn(resetn), .start(start), .vec_valid(vec_valid), .vec_ready(s_vec_ready),
        .vec_stim(vec_stim), .vec_exp(vec_exp), .vec_last(vec_last), .stim_t(s_stim_t), .stim_f(s_stim_f),
        .stim_en(s_stim_en), .share0_t(share0_t), .share1_t(share1_t),
`ifdef FAB_DUALRAIL_CHECK_EN
        .share0_f(share0_f), .share1_f(share1_f), .rail_fault(s_rail_fault),
`endif
        .busy(s_busy), .done(s_done), .pass(s_pass), .vec_count(s_vec_count), .err_count(s_err_count),
        .fail_index(s_fail_index), .fail_got(s_fail_got), .fail_exp(s_fail_exp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_vec(input logic [7:0] s, input logic [7:0] e, input logic l, output int w);
        vec_valid = 1'b1; vec_stim = s; vec_exp = e; vec_last = l;
        w = 0;
        while (!vec_ready && w < 40) begin
            @(negedge CLK);
            w++;
        end
        if (!vec_ready) chk("hs_timeout", 64'd0, 64'd1);
        @(negedge CLK);
        vec_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_stim = 8'h00; vec_exp = 8'h00; vec_last = 1'b0;
`ifdef FAB_DUALRAIL_CHECK_EN
        flip = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset then idle
        chk("rst_vec_ready", 64'(vec_ready), 64'd0);
        chk("rst_stim_f", 64'(stim_f), 64'hFF);
        chk("rst_stim_t", 64'(stim_t), 64'h00);
        chk("rst_stim_en", 64'(stim_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_counts", {vec_count, err_count, fail_index, fail_got, fail_exp}, 64'd0);

        // Single passing vector: 0x2B ^ 0xDA = 0xF1
        pulse_start();
        chk("ready_after_start", 64'(vec_ready), 64'd1);
        chk("busy_after_start", 64'(busy), 64'd1);
        send_vec(8'h2B, 8'hF1, 1'b1, waits);
        chk("rails_applied", {stim_en, stim_t, stim_f}, {55'd0, 1'b1, 8'h2B, 8'hD4});
        wait_done(waits);
        chk("settle_latency", 64'(waits), 64'd2);
        chk("single_flags", {done, pass, busy, stim_en}, 64'b1100);
        chk("single_counts", {vec_count, err_count}, 64'h0001_0000);
        chk("single_hold_rails", {stim_t, stim_f}, 64'h2BD4);

        // 32 back-to-back vectors
        pulse_start();
        min_w = 99; max_w = 0;
        for (int i = 0; i < 32; i++) begin
            st = 8'(i * 37 + 5);
            send_vec(st, st ^ 8'hDA, i == 31, waits);
            if (i > 0) begin
                if (waits < min_w) min_w = waits;
                if (waits > max_w) max_w = waits;
            end
        end
        chk("stream_gap_min", 64'(min_w), 64'd2);
        chk("stream_gap_max", 64'(max_w), 64'd2);
        wait_done(waits);
        chk("stream_vec_count", 64'(vec_count), 64'd32);
        chk("stream_err_pass", {err_count, 7'd0, pass}, {16'd0, 8'd1});
        chk("stream_small_wrap", 64'(s_vec_count), 64'd0);

        // Mismatch at vector 5: stim 0x82 gives 0x58, 0x59 expected
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            st = (i == 5) ? 8'h82 : 8'(i * 11 + 1);
            send_vec(st, (i == 5) ? 8'h59 : (st ^ 8'hDA), i == 7, waits);
        end
        wait_done(waits);
        chk("mm_err_count", 64'(err_count), 64'd1);
        chk("mm_fail_index", 64'(fail_index), 64'd5);
        chk("mm_fail_got", 64'(fail_got), 64'h58);
        chk("mm_fail_exp", 64'(fail_exp), 64'h59);
        chk("mm_pass", {done, pass}, 64'b10);
        chk("mm_vec_count", 64'(vec_count), 64'd8);

        // 20 failing vectors: default counts 20, CNT_W=4 saturates at 15 and wraps vec_count to 4
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            st = 8'(i * 13 + 7);
            send_vec(st, st ^ 8'hDA ^ 8'h01, i == 19, waits);
        end
        wait_done(waits);
        chk("sat_big_err", 64'(err_count), 64'd20);
        chk("sat_small_err", 64'(s_err_count), 64'd15);
        chk("sat_small_vec", 64'(s_vec_count), 64'd4);
        chk("sat_fail_first", {fail_index, fail_got, fail_exp}, {32'd0, 8'h07 ^ 8'hDA, 8'h07 ^ 8'hDA ^ 8'h01});
        chk("sat_small_pass", 64'(s_pass), 64'd0);

        // Reset mid-SETTLE aborts the run
        pulse_start();
        send_vec(8'h3C, 8'h00, 1'b0, waits);
        resetn = 1'b0;
        #1;
        chk("abort_flags", {vec_ready, busy, done, stim_en}, 64'd0);
        chk("abort_rails", {stim_t, stim_f}, 64'h00FF);
        chk("abort_counts", {vec_count, err_count, fail_index, fail_got, fail_exp}, 64'd0);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        pulse_start();
        send_vec(8'h10, 8'h10 ^ 8'hDA, 1'b1, waits);
        wait_done(waits);
        chk("restart_pass", {done, pass, vec_count, err_count}, {30'd0, 2'b11, 16'd1, 16'd0});

`ifdef FAB_DUALRAIL_CHECK_EN
        // Corrupted false rail on an otherwise correct vector
        pulse_start();
        flip = 1'b1;
        send_vec(8'h44, 8'h44 ^ 8'hDA, 1'b1, waits);
        wait_done(waits);
        flip = 1'b0;
        chk("rail_fault_set", 64'(rail_fault), 64'd1);
        chk("rail_err", {err_count, fail_got}, {16'd1, 8'h44 ^ 8'hDA});
        pulse_start();
        chk("rail_fault_clear", 64'(rail_fault), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
